// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the stream reader and the downstream consumer.
// The master modport is the reader's view. The slave modport is the FIFO/consumer side.
interface fifo_stream_reader_if #(
   parameter int DATA_SIZE = 8
);
   logic                 fifo_r_en;
   logic                 fifo_r_empty;
   logic [DATA_SIZE-1:0] fifo_r_data;
   logic [DATA_SIZE-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output fifo_r_en, out_data, out_valid,
      input  fifo_r_empty, fifo_r_data, out_ready
   );

   modport slave (
      input  fifo_r_en, out_data, out_valid,
      output fifo_r_empty, fifo_r_data, out_ready
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port with one-cycle read latency into a valid/ready stream.
// It uses a 3-entry prefetch buffer, so the read enable never depends on out_ready.
module fifo_stream_reader #(
   parameter int DATA_SIZE  = 8,
   parameter int COUNT_SIZE = 16
) (
   input  logic                  r_clk,
   input  logic                  r_rst_n,
   input  logic                  en,
   fifo_stream_reader_if.master  bus,
   output logic [COUNT_SIZE-1:0] count,
   output logic                  idle
);
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            head_q, head_d;
   logic [1:0]            tail_q, tail_d;
   logic                  pend_q, pend_d;
   logic [COUNT_SIZE-1:0] count_q, count_d;
   logic [DATA_SIZE-1:0]  buf_q [3];
   logic [DATA_SIZE-1:0]  buf_d [3];
   logic                  issue, push, pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      // Count the in-flight word against capacity so that its capture always has room.
      issue   = en & ~bus.fifo_r_empty & ((3'(occ_q) + 3'(pend_q)) < 3'd3);
      push    = pend_q;
      pop     = (occ_q != 2'd0) & bus.out_ready;
      pend_d  = issue;
      buf_d   = buf_q;
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      count_d = count_q;
      if (push) begin
         buf_d[tail_q] = bus.fifo_r_data;
         tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
         head_d  = ptr_inc(head_q);
         count_d = count_q + COUNT_SIZE'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         occ_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         pend_q  <= 1'b0;
         count_q <= '0;
         buf_q   <= '{default: '0};
      end else begin
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         pend_q  <= pend_d;
         count_q <= count_d;
         buf_q   <= buf_d;
      end
   end

   assign bus.fifo_r_en = issue;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_data  = buf_q[head_q];
   assign count         = count_q;
   assign idle          = (occ_q == 2'd0) & ~pend_q & bus.fifo_r_empty;

   a_no_overflow: assert property (@(posedge r_clk) disable iff (!r_rst_n)
      !(push && !pop && occ_q == 2'd3));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. It uses a model FIFO with registered read data
// and a negedge monitor that records every accepted word.
module tb_fifo_stream_reader;
   logic        r_clk = 1'b0;
   logic        r_rst_n;
   logic        en;
   logic [15:0] count;
   logic        idle;
   logic [3:0]  count4;
   logic        idle4;

   int checks = 0;
   int failures = 0;

   fifo_stream_reader_if #(.DATA_SIZE(8)) bus ();
   fifo_stream_reader_if #(.DATA_SIZE(8)) bus4 ();

   fifo_stream_reader #(.DATA_SIZE(8), .COUNT_SIZE(16)) dut (
      .r_clk(r_clk), .r_rst_n(r_rst_n), .en(en), .bus(bus), .count(count), .idle(idle));

   fifo_stream_reader #(.DATA_SIZE(8), .COUNT_SIZE(4)) dut4 (
      .r_clk(r_clk), .r_rst_n(r_rst_n), .en(en), .bus(bus4), .count(count4), .idle(idle4));

   always #5 r_clk = ~r_clk;

   // Model FIFO for the main DUT: read data is registered one cycle after an accepted read.
   logic [7:0] mem [256];
   int wptr = 0;
   int rptr = 0;
   int issued = 0;
   assign bus.fifo_r_empty = (rptr == wptr);
   always @(posedge r_clk) begin
      if (bus.fifo_r_en && rptr != wptr) begin
         bus.fifo_r_data <= mem[rptr[7:0]];
         rptr   <= rptr + 1;
         issued <= issued + 1;
      end
   end

   // Word-source model for the narrow-counter instance.
   int wr4 = 0;
   int rd4 = 0;
   assign bus4.fifo_r_empty = (rd4 == wr4);
   assign bus4.out_ready    = 1'b1;
   always @(posedge r_clk) begin
      if (bus4.fifo_r_en && rd4 != wr4) begin
         bus4.fifo_r_data <= 8'(rd4);
         rd4 <= rd4 + 1;
      end
   end

   // Monitor: a word seen valid&ready here is popped on the following posedge.
   logic [7:0] recv [256];
   int rn = 0;
   int max_out = 0;
   always @(negedge r_clk) begin
      if (r_rst_n && (issued - rn) > max_out) max_out = issued - rn;
      if (r_rst_n && bus.out_valid && bus.out_ready) begin
         recv[rn[7:0]] = bus.out_data;
         rn = rn + 1;
      end
   end

   task automatic load(input logic [7:0] w);
      mem[wptr[7:0]] = w;
      wptr = wptr + 1;
   endtask

   task automatic test_reset;
      for (int c = 0; c < 10; c++) begin
         @(negedge r_clk);
         checks += 4;
         if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL rst_r_en cyc=%0d got=%b exp=0", c, bus.fifo_r_en); end
         if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid cyc=%0d got=%b exp=0", c, bus.out_valid); end
         if (count !== 16'd0) begin failures++; $display("FAIL rst_count cyc=%0d got=%0d exp=0", c, count); end
         if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle cyc=%0d got=%b exp=1", c, idle); end
      end
   endtask

   task automatic test_latency;
      @(posedge r_clk); #1;
      load(8'h11); load(8'h22); load(8'h33);
      @(negedge r_clk);
      checks += 2;
      if (bus.fifo_r_en !== 1'b1) begin failures++; $display("FAIL lat_r_en_n got=%b exp=1", bus.fifo_r_en); end
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_n got=%b exp=0", bus.out_valid); end
      @(negedge r_clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_n1 got=%b exp=0", bus.out_valid); end
      for (int i = 0; i < 3; i++) begin
         logic [7:0] exp_w;
         exp_w = 8'(8'h11 * (i + 1));
         @(negedge r_clk);
         checks += 2;
         if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid idx=%0d got=%b exp=1", i, bus.out_valid); end
         if (bus.out_data !== exp_w) begin failures++; $display("FAIL lat_data idx=%0d got=%h exp=%h", i, bus.out_data, exp_w); end
      end
      @(negedge r_clk);
      checks += 3;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_end got=%b exp=0", bus.out_valid); end
      if (count !== 16'd3) begin failures++; $display("FAIL lat_count got=%0d exp=3", count); end
      if (idle !== 1'b1) begin failures++; $display("FAIL lat_idle got=%b exp=1", idle); end
   endtask

   task automatic test_backpressure;
      int i0;
      @(posedge r_clk); #1;
      bus.out_ready = 1'b0;
      i0 = issued;
      for (int i = 0; i < 8; i++) load(8'(8'h11 * (i + 1)));
      repeat (5) @(negedge r_clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge r_clk);
         checks += 3;
         if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL bp_r_en cyc=%0d got=%b exp=0", c, bus.fifo_r_en); end
         if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
         if (bus.out_data !== 8'h11) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=11", c, bus.out_data); end
      end
      checks++;
      if (issued - i0 != 3) begin failures++; $display("FAIL bp_reads got=%0d exp=3", issued - i0); end
      @(posedge r_clk); #1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] exp_w;
         exp_w = 8'(8'h11 * (i + 1));
         @(negedge r_clk);
         checks += 2;
         if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_rel_valid idx=%0d got=%b exp=1", i, bus.out_valid); end
         if (bus.out_data !== exp_w) begin failures++; $display("FAIL bp_rel_data idx=%0d got=%h exp=%h", i, bus.out_data, exp_w); end
      end
      @(negedge r_clk);
      checks += 2;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%b exp=0", bus.out_valid); end
      if (count !== 16'd11) begin failures++; $display("FAIL bp_count got=%0d exp=11", count); end
   endtask

   task automatic test_toggle;
      int rn0;
      int c;
      rn0 = rn;
      @(posedge r_clk); #1;
      for (int i = 0; i < 20; i++) load(8'(8'h40 + i));
      c = 0;
      while (rn - rn0 < 20 && c < 200) begin
         @(posedge r_clk); #1;
         bus.out_ready = ~bus.out_ready;
         c++;
      end
      bus.out_ready = 1'b1;
      repeat (5) @(negedge r_clk);
      checks += 3;
      if (rn - rn0 != 20) begin failures++; $display("FAIL tog_words got=%0d exp=20", rn - rn0); end
      if (max_out > 3) begin failures++; $display("FAIL tog_outstanding got=%0d exp<=3", max_out); end
      if (count !== 16'd31) begin failures++; $display("FAIL tog_count got=%0d exp=31", count); end
      for (int i = 0; i < 20; i++) begin
         logic [7:0] exp_w;
         int idx;
         exp_w = 8'(8'h40 + i);
         idx = rn0 + i;
         checks++;
         if (recv[idx[7:0]] !== exp_w) begin failures++; $display("FAIL tog_data idx=%0d got=%h exp=%h", i, recv[idx[7:0]], exp_w); end
      end
   endtask

   task automatic test_en_drop;
      int rn0;
      rn0 = rn;
      @(posedge r_clk); #1;
      load(8'hD0); load(8'hD1); load(8'hD2);
      @(posedge r_clk); #1;
      en = 1'b0;
      @(negedge r_clk);
      checks++;
      if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL en_r_en got=%b exp=0", bus.fifo_r_en); end
      @(negedge r_clk);
      checks += 2;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL en_inflight_valid got=%b exp=1", bus.out_valid); end
      if (bus.out_data !== 8'hD0) begin failures++; $display("FAIL en_inflight_data got=%h exp=d0", bus.out_data); end
      for (int c = 0; c < 3; c++) begin
         @(negedge r_clk);
         checks += 2;
         if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL en_hold_r_en cyc=%0d got=%b exp=0", c, bus.fifo_r_en); end
         if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL en_hold_valid cyc=%0d got=%b exp=0", c, bus.out_valid); end
      end
      checks++;
      if (count !== 16'd32) begin failures++; $display("FAIL en_count_mid got=%0d exp=32", count); end
      @(posedge r_clk); #1;
      en = 1'b1;
      repeat (6) @(negedge r_clk);
      checks += 5;
      if (count !== 16'd34) begin failures++; $display("FAIL en_count_end got=%0d exp=34", count); end
      if (idle !== 1'b1) begin failures++; $display("FAIL en_idle got=%b exp=1", idle); end
      if (rn - rn0 != 3) begin failures++; $display("FAIL en_words got=%0d exp=3", rn - rn0); end
      if (recv[8'(rn0 + 1)] !== 8'hD1) begin failures++; $display("FAIL en_data1 got=%h exp=d1", recv[8'(rn0 + 1)]); end
      if (recv[8'(rn0 + 2)] !== 8'hD2) begin failures++; $display("FAIL en_data2 got=%h exp=d2", recv[8'(rn0 + 2)]); end
   endtask

   task automatic test_reset_mid;
      int rn0;
      @(posedge r_clk); #1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) load(8'(8'hC0 + i));
      repeat (3) @(posedge r_clk);
      @(negedge r_clk);
      checks += 2;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b exp=1", bus.out_valid); end
      if (bus.out_data !== 8'hC0) begin failures++; $display("FAIL rm_pre_data got=%h exp=c0", bus.out_data); end
      #1 r_rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", bus.out_valid); end
      if (count !== 16'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", count); end
      if (bus.out_data !== 8'h00) begin failures++; $display("FAIL rm_data got=%h exp=00", bus.out_data); end
      #1 r_rst_n = 1'b1;
      bus.out_ready = 1'b1;
      rn0 = rn;
      repeat (8) @(negedge r_clk);
      // Words C0..C2 were already pulled from the FIFO when reset hit, so only C3 and C4 remain.
      checks += 4;
      if (rn - rn0 != 2) begin failures++; $display("FAIL rm_words got=%0d exp=2", rn - rn0); end
      if (recv[8'(rn0)] !== 8'hC3) begin failures++; $display("FAIL rm_data0 got=%h exp=c3", recv[8'(rn0)]); end
      if (recv[8'(rn0 + 1)] !== 8'hC4) begin failures++; $display("FAIL rm_data1 got=%h exp=c4", recv[8'(rn0 + 1)]); end
      if (count !== 16'd2) begin failures++; $display("FAIL rm_count_after got=%0d exp=2", count); end
   endtask

   task automatic test_count_wrap;
      int c;
      @(posedge r_clk); #1;
      wr4 = 17;
      c = 0;
      do begin
         @(negedge r_clk);
         c++;
      end while (!(idle4 && rd4 == 17) && c < 100);
      checks += 2;
      if (c >= 100) begin failures++; $display("FAIL wrap_timeout got=%0d cycles exp<100", c); end
      if (count4 !== 4'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", count4); end
   endtask

   initial begin
      r_rst_n       = 1'b0;
      en            = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge r_clk);
      #1 r_rst_n = 1'b1;
      test_reset;
      test_latency;
      test_backpressure;
      test_toggle;
      test_en_drop;
      test_reset_mid;
      test_count_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
